// File: rtl/sigmoid_pkg.sv
// rtl/sigmoid_pkg.sv - shared types and constants for the sigmoid Wishbone initiator
package sigmoid_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [31:0] SIGMOID_ADDR = 32'h3000_0000;
    localparam logic [3:0]  WB_SEL_ALL   = 4'hF;
    localparam int          X_W          = 8;
    localparam int          Y_W          = 16;

    // Sign-extend a sample to the 32-bit Wishbone data width.
    function automatic logic [31:0] sext_x(input logic [X_W-1:0] x);
        return {{(32-X_W){x[X_W-1]}}, x};
    endfunction

endpackage

// File: rtl/sigmoid_wb_initiator_if.sv
// rtl/sigmoid_wb_initiator_if.sv - sample/result streams and Wishbone classic bus
interface sigmoid_wb_initiator_if;
    import sigmoid_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [X_W-1:0]   in_x;
    logic             out_valid;
    logic             out_ready;
    logic [Y_W-1:0]   out_y;
    logic             out_err;
    logic             busy_o;
    logic             wbm_cyc_o;
    logic             wbm_stb_o;
    logic             wbm_we_o;
    logic [3:0]       wbm_sel_o;
    logic [31:0]      wbm_adr_o;
    logic [31:0]      wbm_dat_o;
    logic [31:0]      wbm_dat_i;
    logic             wbm_ack_i;

    // Initiator side: consumes samples, produces results, masters the bus.
    modport master (
        input  in_valid, in_x, out_ready, wbm_dat_i, wbm_ack_i,
        output in_ready, out_valid, out_y, out_err, busy_o,
               wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );

    // Environment side: sample producer, result consumer and Wishbone slave.
    modport slave (
        output in_valid, in_x, out_ready, wbm_dat_i, wbm_ack_i,
        input  in_ready, out_valid, out_y, out_err, busy_o,
               wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );

endinterface

// File: rtl/wb_timeout_ctr.sv
// rtl/wb_timeout_ctr.sv - per-transaction acknowledge timeout counter
module wb_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    // Restart on every new bus phase, otherwise count cycles spent waiting for ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + W'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/sigmoid_wb_initiator.sv
// rtl/sigmoid_wb_initiator.sv - streams samples to the sigmoid slave and returns results
module sigmoid_wb_initiator
    import sigmoid_pkg::*;
#(
    parameter logic [31:0] ADDR    = SIGMOID_ADDR,
    parameter int          TIMEOUT = 16
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_ni,
    sigmoid_wb_initiator_if.master  bus
);

    state_t          state;
    logic            cyc_q;
    logic            stb_q;
    logic            we_q;
    logic [3:0]      sel_q;
    logic [31:0]     adr_q;
    logic [31:0]     dat_q;
    logic [Y_W-1:0]  y_q;
    logic            err_q;

    logic            ack;
    logic            tmo_clear;
    logic            tmo_enable;
    logic            tmo_expired;

    // Ack only matters while a strobe is out; elsewhere it is ignored by the FSM.
    assign ack        = bus.wbm_ack_i;
    assign tmo_clear  = ((state == IDLE) && bus.in_valid) || ((state == WRITE) && ack);
    assign tmo_enable = ((state == WRITE) || (state == READ)) && !ack;

    wb_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_ni),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    // Transaction sequencer: write sample, read result, hold result until consumed.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= IDLE;
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
            we_q  <= 1'b0;
            sel_q <= '0;
            adr_q <= '0;
            dat_q <= '0;
            y_q   <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        state <= WRITE;
                        cyc_q <= 1'b1;
                        stb_q <= 1'b1;
                        we_q  <= 1'b1;
                        sel_q <= WB_SEL_ALL;
                        adr_q <= ADDR;
                        dat_q <= sext_x(bus.in_x);
                    end
                end
                WRITE: begin
                    if (ack) begin
                        state <= READ;
                        we_q  <= 1'b0;
                        dat_q <= '0;
                    end else if (tmo_expired) begin
                        // Abandon the sample entirely; the read phase is skipped.
                        state <= RESP;
                        cyc_q <= 1'b0;
                        stb_q <= 1'b0;
                        we_q  <= 1'b0;
                        sel_q <= '0;
                        adr_q <= '0;
                        dat_q <= '0;
                        y_q   <= '0;
                        err_q <= 1'b1;
                    end
                end
                READ: begin
                    if (ack || tmo_expired) begin
                        // Ack has priority over a same-cycle expiry.
                        state <= RESP;
                        cyc_q <= 1'b0;
                        stb_q <= 1'b0;
                        sel_q <= '0;
                        adr_q <= '0;
                        y_q   <= ack ? bus.wbm_dat_i[Y_W-1:0] : '0;
                        err_q <= !ack;
                    end
                end
                RESP: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == RESP);
    assign bus.busy_o    = (state == WRITE) || (state == READ);
    assign bus.out_y     = y_q;
    assign bus.out_err   = err_q;
    assign bus.wbm_cyc_o = cyc_q;
    assign bus.wbm_stb_o = stb_q;
    assign bus.wbm_we_o  = we_q;
    assign bus.wbm_sel_o = sel_q;
    assign bus.wbm_adr_o = adr_q;
    assign bus.wbm_dat_o = dat_q;

endmodule

// File: tb/tb_sigmoid_wb_initiator.sv
// tb/tb_sigmoid_wb_initiator.sv - randomized self-checking bench for sigmoid_wb_initiator
module tb_sigmoid_wb_initiator;

    localparam int          TIMEOUT = 16;
    localparam logic [31:0] ADDR    = 32'h3000_0000;
    localparam int          NEVER   = 1000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    sigmoid_wb_initiator_if bus();

    sigmoid_wb_initiator #(
        .ADDR    (ADDR),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One sample end to end. w1/w2 = wait states before ack on write/read (>=TIMEOUT: never acks in time).
    task automatic run_txn(input logic [7:0] x, input int w1, input int w2,
                           input logic [31:0] rdata, input int hold);
        int          xi;
        logic [31:0] exp_wdata;
        int          exp_wr, exp_rd, exp_valid;
        logic        exp_err;
        logic [15:0] exp_y, y0;
        int          wr_seen, rd_seen, cyc_n, valid_at;
        logic        bad_ready, bad_busy, bad_addr, bad_wdata, bad_hold;

        // Reference: plain arithmetic on the transaction's wait profile.
        xi        = $signed(x);
        exp_wdata = xi;
        exp_wr    = (w1 >= TIMEOUT) ? TIMEOUT : w1 + 1;
        exp_rd    = (w1 >= TIMEOUT) ? 0 : ((w2 >= TIMEOUT) ? TIMEOUT : w2 + 1);
        exp_valid = exp_wr + exp_rd + 1;
        exp_err   = (w1 >= TIMEOUT) || (w2 >= TIMEOUT);
        exp_y     = exp_err ? 16'h0000 : rdata[15:0];

        wr_seen = 0; rd_seen = 0; valid_at = 0; cyc_n = 1;
        bad_ready = 0; bad_busy = 0; bad_addr = 0; bad_wdata = 0; bad_hold = 0;

        @(negedge clk);
        check_eq("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_x     = x;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_x     = 8'($urandom);

        while (valid_at == 0 && cyc_n <= 300) begin
            if (bus.out_valid) begin
                valid_at = cyc_n;
            end else begin
                if (bus.in_ready) bad_ready = 1;
                if (!bus.busy_o || !bus.wbm_cyc_o || !bus.wbm_stb_o) bad_busy = 1;
                bus.wbm_ack_i = 1'b0;
                bus.wbm_dat_i = $urandom;
                if (bus.wbm_cyc_o && bus.wbm_stb_o) begin
                    if (bus.wbm_adr_o !== ADDR || bus.wbm_sel_o !== 4'hF) bad_addr = 1;
                    if (bus.wbm_we_o) begin
                        if (bus.wbm_dat_o !== exp_wdata) bad_wdata = 1;
                        if (rd_seen != 0) bad_busy = 1;
                        if (wr_seen == w1) bus.wbm_ack_i = 1'b1;
                        wr_seen++;
                    end else begin
                        if (bus.wbm_dat_o !== 32'd0) bad_wdata = 1;
                        if (rd_seen == w2) begin
                            bus.wbm_ack_i = 1'b1;
                            bus.wbm_dat_i = rdata;
                        end
                        rd_seen++;
                    end
                end
                @(posedge clk); #1;
                cyc_n++;
            end
        end
        bus.wbm_ack_i = 1'b0;

        check_eq("valid_cycle", valid_at, exp_valid);
        check_eq("write_strobes", wr_seen, exp_wr);
        check_eq("read_strobes", rd_seen, exp_rd);
        check_eq("out_y", {16'd0, bus.out_y}, {16'd0, exp_y});
        check_eq("out_err", {31'd0, bus.out_err}, {31'd0, exp_err});
        check_eq("ready_low_busy", {31'd0, bad_ready}, 32'd0);
        check_eq("busy_strobe", {31'd0, bad_busy}, 32'd0);
        check_eq("adr_sel", {31'd0, bad_addr}, 32'd0);
        check_eq("wdata", {31'd0, bad_wdata}, 32'd0);
        check_eq("resp_bus_idle", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o,
                                   |bus.wbm_adr_o, |bus.wbm_dat_o, bus.busy_o}, 32'd0);

        // Consumer stalls while a new sample and stray acks are offered.
        y0 = bus.out_y;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid  = 1'b1;
            bus.wbm_ack_i = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (bus.out_y !== y0 || !bus.out_valid || bus.in_ready || bus.wbm_cyc_o) bad_hold = 1;
        end
        bus.in_valid  = 1'b0;
        bus.wbm_ack_i = 1'b0;
        check_eq("resp_hold", {31'd0, bad_hold}, 32'd0);

        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check_eq("after_take", {bus.out_valid, bus.in_ready, bus.out_y}, {2'b01, y0});
    endtask

    initial begin
        int sel;
        int w1, w2;

        bus.in_valid  = 1'b0;
        bus.in_x      = 8'd0;
        bus.out_ready = 1'b0;
        bus.wbm_ack_i = 1'b0;
        bus.wbm_dat_i = 32'd0;

        repeat (2) @(negedge clk);
        check_eq("rst_stream", {bus.in_ready, bus.out_valid, bus.out_err, bus.busy_o, bus.out_y},
                 {4'b1000, 16'h0000});
        check_eq("rst_wb_ctl", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o}, 32'd0);
        check_eq("rst_wb_adr", bus.wbm_adr_o, 32'd0);
        check_eq("rst_wb_dat", bus.wbm_dat_o, 32'd0);
        rst_n = 1'b1;

        // Directed cases from the behavioural description.
        run_txn(8'h10, 0, 0, 32'h0000_0080, 0);
        run_txn(8'hF0, 0, 0, 32'h1234_5678, 0);
        run_txn(8'h7F, 3, 3, 32'hABCD_0123, 1);
        run_txn(8'h80, NEVER, NEVER, 32'hFFFF_FFFF, 0);
        run_txn(8'h01, 0, NEVER, 32'h5555_AAAA, 0);
        run_txn(8'h22, TIMEOUT - 1, TIMEOUT - 1, 32'h0000_BEEF, 0);
        run_txn(8'h33, 2, 1, 32'h0000_4321, 10);

        // Asynchronous reset while the read strobe is out.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_x     = 8'h55;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.wbm_ack_i = 1'b1;
        @(posedge clk); #1;
        bus.wbm_ack_i = 1'b0;
        check_eq("pre_rst_read", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o}, 32'b110);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.out_valid, bus.in_ready}, 32'b0001);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_txn(8'hC3, 1, 0, 32'h0000_7E57, 0);

        // Randomized profiles, biased toward the timeout boundary now and then.
        for (int n = 0; n < 30; n++) begin
            sel = $urandom_range(0, 9);
            w1  = (sel == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 1) : $urandom_range(0, 4);
            sel = $urandom_range(0, 9);
            w2  = (sel == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 1) : $urandom_range(0, 4);
            run_txn(8'($urandom), w1, w2, $urandom, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
